// File: rtl/uart_rx_fifo_if.sv
// Byte/flag bundle between uart_rx, the receive FIFO and the CPU input channel.
interface uart_rx_fifo_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [WIDTH-1:0]    rx_byte;
    logic                rx_done_n;
    logic                fg_in;
    logic [WIDTH-1:0]    inpr;
    logic                fg_in_set_n;
    logic [DEPTH_LOG2:0] count;
    logic                empty;
    logic                full;
    logic                overflow;

    modport master (
        output rx_byte, rx_done_n, fg_in,
        input  inpr, fg_in_set_n, count, empty, full, overflow
    );

    modport slave (
        input  rx_byte, rx_done_n, fg_in,
        output inpr, fg_in_set_n, count, empty, full, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and CPU input channel 1: queues completed bytes and
// hands them to the CPU one at a time through the FGI set strobe / clear handshake.
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RETRY   = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_prev_done_n;
    logic                  r_set_n;
    logic                  r_retry;
    state_t                r_state;

    state_t                w_state_nxt;
    logic                  w_set_n_nxt;
    logic                  w_retry_nxt;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    assign w_empty    = (r_count == {(DEPTH_LOG2+1){1'b0}});
    assign w_full     = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign w_push_req = r_prev_done_n & ~bus.rx_done_n;
    assign w_pop      = (r_state == WAIT_LO) & ~bus.fg_in;
    // A pop on the same edge frees a slot, so a push into a full queue is still accepted.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    assign bus.inpr        = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign bus.fg_in_set_n = r_set_n;
    assign bus.count       = r_count;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.overflow    = r_overflow;

    // Storage array write port; contents need no reset since inpr is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_byte;
        end
    end

    // Pointers, occupancy, sticky overflow and rx_done_n edge detector.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr      <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr      <= {DEPTH_LOG2{1'b0}};
            r_count       <= {(DEPTH_LOG2+1){1'b0}};
            r_overflow    <= 1'b0;
            r_prev_done_n <= 1'b1;
        end else begin
            r_prev_done_n <= bus.rx_done_n;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Handshake FSM state, registered strobe and retry cycle marker.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_set_n <= 1'b1;
            r_retry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_set_n <= w_set_n_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state logic: strobe once, give the CPU two extra cycles to raise FGI, then re-strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_set_n_nxt = 1'b1;
        w_retry_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !bus.fg_in) begin
                    w_state_nxt = STROBE;
                    w_set_n_nxt = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STROBE: begin
                if (bus.fg_in) begin
                    w_state_nxt = WAIT_LO;
                end else begin
                    w_state_nxt = RETRY;
                end
            end
            RETRY: begin
                if (bus.fg_in) begin
                    w_state_nxt = WAIT_LO;
                end else if (r_retry) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_retry_nxt = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.fg_in) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_LO;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end
endmodule
